// File: rtl/inst_mem_burst_responder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_mem_burst_responder
//  Purpose  : Memory-side end of the instruction-fetch read bus. Queues burst
//             read commands and streams each burst's beats, one per cycle at a
//             fixed latency, from an internal word-addressed instruction RAM.
//             A side port loads the RAM; i_flush drops queued and in-flight
//             reads on a control-flow redirect.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   clock
//    rst              in   synchronous reset, active-high
//    i_addr           in   burst start byte address
//    i_read           in   read command request
//    i_burstcount     in   beats in burst (0 is treated as 1)
//    o_waitrequest    out  command not accepted this cycle
//    o_readdata       out  returned beat
//    o_readdatavalid  out  o_readdata valid
//    i_flush          in   drop queued commands and in-flight beats
//    i_load_addr      in   RAM word index to write
//    i_load_data      in   RAM write data
//    i_load_we        in   RAM write enable
// ============================================================================
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module inst_mem_burst_responder #(
    parameter int p_addr_bits       = `MEM_ADDR_BITS,
    parameter int p_data_bits       = `WORD_BITS,
    parameter int p_depth_log2      = 10,
    parameter int p_cmd_fifo_length = 4,
    parameter int p_cmd_fifo_log2   = 2,
    parameter int p_read_latency    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [p_addr_bits-1:0]  i_addr,
    input  logic                    i_read,
    input  logic [p_data_bits-1:0]  i_burstcount,
    output logic                    o_waitrequest,
    output logic [p_data_bits-1:0]  o_readdata,
    output logic                    o_readdatavalid,
    input  logic                    i_flush,
    input  logic [p_depth_log2-1:0] i_load_addr,
    input  logic [p_data_bits-1:0]  i_load_data,
    input  logic                    i_load_we
);

    localparam int c_byte_bits = $clog2(p_data_bits / 8);
    localparam int c_depth     = 1 << p_depth_log2;

    localparam logic [p_cmd_fifo_log2:0] c_fifo_full = p_cmd_fifo_length[p_cmd_fifo_log2:0];
    localparam logic [p_data_bits-1:0]   c_cnt_one   = {{(p_data_bits-1){1'b0}}, 1'b1};
    localparam logic [p_depth_log2-1:0]  c_idx_one   = {{(p_depth_log2-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic [p_addr_bits-1:0]  w_addr_word;
    logic [p_depth_log2-1:0] w_cmd_idx;
    logic [p_data_bits-1:0]  w_cmd_cnt;
    logic                    w_unused;

    assign w_addr_word = i_addr >> c_byte_bits;
    assign w_cmd_idx   = w_addr_word[p_depth_log2-1:0];
    assign w_cmd_cnt   = (i_burstcount == '0) ? c_cnt_one : i_burstcount;
    // Byte-offset and high address bits are intentionally ignored.
    assign w_unused    = ^{w_addr_word, i_addr};

    // ------------------------------------------------------------------
    // Pending-command queue
    // ------------------------------------------------------------------
    logic [p_depth_log2-1:0]    r_fifo_idx_q [p_cmd_fifo_length];
    logic [p_data_bits-1:0]     r_fifo_cnt_q [p_cmd_fifo_length];
    logic [p_cmd_fifo_log2-1:0] r_wr_ptr_q;
    logic [p_cmd_fifo_log2-1:0] r_rd_ptr_q;
    logic [p_cmd_fifo_log2:0]   r_count_q;

    logic                       w_empty;
    logic                       w_full;
    logic                       w_waitreq;
    logic                       w_push;
    logic                       w_pop;
    logic [p_depth_log2-1:0]    w_head_idx;
    logic [p_data_bits-1:0]     w_head_cnt;

    assign w_empty    = (r_count_q == '0);
    assign w_full     = (r_count_q == c_fifo_full);
    // A full queue refuses the push even when a pop happens in the same cycle.
    assign w_waitreq  = rst | i_flush | w_full;
    assign w_push     = i_read & ~w_waitreq;
    assign w_head_idx = r_fifo_idx_q[r_rd_ptr_q];
    assign w_head_cnt = r_fifo_cnt_q[r_rd_ptr_q];

    assign o_waitrequest = w_waitreq;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_idx_q[r_wr_ptr_q] <= w_cmd_idx;
                r_fifo_cnt_q[r_wr_ptr_q] <= w_cmd_cnt;
                r_wr_ptr_q               <= r_wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr_q <= r_rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count_q <= r_count_q + 1'b1;
                2'b01:   r_count_q <= r_count_q - 1'b1;
                default: r_count_q <= r_count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst sequencer
    // ------------------------------------------------------------------
    state_t                  r_state_q, w_state_d;
    logic [p_depth_log2-1:0] r_idx_q,   w_idx_d;
    logic [p_data_bits-1:0]  r_rem_q,   w_rem_d;
    logic                    w_issue;
    logic [p_depth_log2-1:0] w_issue_idx;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state_q <= S_IDLE;
            r_idx_q   <= '0;
            r_rem_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_rem_q   <= w_rem_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_rem_d     = r_rem_q;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_issue_idx = r_idx_q;
        case (r_state_q)
            S_IDLE: begin
                // The popped command's first beat is issued in the same cycle,
                // so an accept into an idle responder costs only one cycle.
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_issue     = 1'b1;
                    w_issue_idx = w_head_idx;
                    w_idx_d     = w_head_idx + c_idx_one;
                    w_rem_d     = w_head_cnt - c_cnt_one;
                    if (w_head_cnt != c_cnt_one) begin
                        w_state_d = S_BURST;
                    end
                end
            end
            S_BURST: begin
                w_issue     = 1'b1;
                w_issue_idx = r_idx_q;
                if (r_rem_q == c_cnt_one) begin
                    // Last beat: chain straight into the next command.
                    if (!w_empty) begin
                        w_pop   = 1'b1;
                        w_idx_d = w_head_idx;
                        w_rem_d = w_head_cnt;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end else begin
                    w_idx_d = r_idx_q + c_idx_one;
                    w_rem_d = r_rem_q - c_cnt_one;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [p_data_bits-1:0] r_mem_q [c_depth];

    always_ff @(posedge clk) begin
        if (i_load_we && !rst) begin
            r_mem_q[i_load_addr] <= i_load_data;
        end
    end

    // ------------------------------------------------------------------
    // Read-return pipeline: stage 0 captures the RAM word at the issue edge
    // (old data on a same-cycle load), the last stage drives the outputs.
    // ------------------------------------------------------------------
    logic [p_read_latency-1:0] r_pipe_vld_q;
    logic [p_data_bits-1:0]    r_pipe_data_q [p_read_latency];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld_q <= '0;
            for (int k = 0; k < p_read_latency; k++) begin
                r_pipe_data_q[k] <= '0;
            end
        end else begin
            r_pipe_vld_q[0]  <= w_issue & ~i_flush;
            r_pipe_data_q[0] <= r_mem_q[w_issue_idx];
            for (int k = 1; k < p_read_latency; k++) begin
                r_pipe_vld_q[k]  <= r_pipe_vld_q[k-1];
                r_pipe_data_q[k] <= r_pipe_data_q[k-1];
            end
            if (i_flush) begin
                r_pipe_vld_q <= '0;
            end
        end
    end

    assign o_readdatavalid = r_pipe_vld_q[p_read_latency-1];
    assign o_readdata      = r_pipe_data_q[p_read_latency-1];

endmodule

`default_nettype wire
